// File: rtl/memory_bus_responder.sv
// Memory-bus target: word RAM in low memory plus a 256-byte debug IO window
// (RGB LED, 8-bit LED bank, two synchronised buttons).
module memory_bus_responder #(
    parameter int          ADDRESS_SIZE = 15,
    parameter int          RAM_WORDS    = 2048,
    parameter int unsigned IO_BASE      = 32'h7F00
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    strobe,
    input  logic                    isWrite,
    input  logic [ADDRESS_SIZE-1:0] address,
    input  logic [3:0]              writeMask,
    input  logic [31:0]             dataWrite,
    output logic                    ready,
    output logic                    error,
    output logic [31:0]             dataRead,
    input  logic                    btnA,
    input  logic                    btnB,
    output logic                    red,
    output logic                    green,
    output logic                    blue,
    output logic [7:0]              bits
);

    localparam int          WORD_AW   = $clog2(RAM_WORDS);
    localparam int unsigned RAM_BYTES = 32'(4 * RAM_WORDS);
    localparam int unsigned IO_END    = IO_BASE + 32'd256;

    typedef enum logic [1:0] {
        IDLE,
        RAM_READ,
        RESPOND
    } state_t;

    state_t              state_reg, state_next;
    logic                err_reg;
    logic [31:0]         data_read_reg;
    logic [31:0]         ram_q_reg;
    logic                red_reg, green_reg, blue_reg;
    logic [7:0]          bits_reg;
    logic [1:0]          btn_meta_reg, btn_sync_reg;
    logic [31:0]         mem [RAM_WORDS];

    logic [31:0]         addr_u;
    logic [7:0]          io_off;
    logic [WORD_AW-1:0]  ram_idx;
    logic                accept, in_ram, in_io, req_err;
    logic                ram_wr, ram_rd, io_acc;
    logic [31:0]         io_rdata;

    assign addr_u   = 32'(address);
    assign io_off   = 8'(addr_u - IO_BASE);
    assign ram_idx  = address[WORD_AW+1:2];
    assign dataRead = data_read_reg;
    assign red      = red_reg;
    assign green    = green_reg;
    assign blue     = blue_reg;
    assign bits     = bits_reg;

    // Request decode: classify the presented address and build the IO read value.
    always_comb begin
        accept   = (state_reg == IDLE) && strobe;
        in_ram   = addr_u < RAM_BYTES;
        in_io    = (addr_u >= IO_BASE) && (addr_u < IO_END);
        req_err  = (address[1:0] != 2'b00) || !(in_ram || in_io);
        ram_wr   = accept && !req_err && in_ram && isWrite;
        ram_rd   = accept && !req_err && in_ram && !isWrite;
        io_acc   = accept && !req_err && in_io;
        io_rdata = '0;
        case (io_off)
            8'h00:   io_rdata[2:0] = {blue_reg, green_reg, red_reg};
            8'h04:   io_rdata[7:0] = bits_reg;
            8'h08:   io_rdata[1:0] = btn_sync_reg;
            default: io_rdata      = '0;
        endcase
    end

    // Next-state logic and response outputs; ready is high only in RESPOND.
    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        error      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = ram_rd ? RAM_READ : RESPOND;
                end
            end
            RAM_READ: begin
                state_next = RESPOND;
            end
            RESPOND: begin
                ready      = 1'b1;
                error      = err_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Block RAM: byte-enabled write and registered read, both in the accept cycle.
    always_ff @(posedge clock) begin
        if (ram_wr && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (writeMask[b]) begin
                    mem[ram_idx][8*b +: 8] <= dataWrite[8*b +: 8];
                end
            end
        end
        if (ram_rd) begin
            ram_q_reg <= mem[ram_idx];
        end
    end

    // State register, error flag and read-data register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            err_reg       <= 1'b0;
            data_read_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                err_reg <= req_err;
            end
            if (accept && req_err) begin
                data_read_reg <= '0;
            end else if (io_acc && !isWrite) begin
                data_read_reg <= io_rdata;
            end else if (state_reg == RAM_READ) begin
                data_read_reg <= ram_q_reg;
            end
        end
    end

    // IO registers: LED writes take effect at the accept edge, visible in the ready cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            red_reg   <= 1'b0;
            green_reg <= 1'b0;
            blue_reg  <= 1'b0;
            bits_reg  <= '0;
        end else if (io_acc && isWrite && writeMask[0]) begin
            case (io_off)
                8'h00: {blue_reg, green_reg, red_reg} <= dataWrite[2:0];
                8'h04: bits_reg <= dataWrite[7:0];
                default: ;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_meta_reg <= '0;
            btn_sync_reg <= '0;
        end else begin
            btn_meta_reg <= {btnB, btnA};
            btn_sync_reg <= btn_meta_reg;
        end
    end

endmodule

// File: tb/tb_memory_bus_responder.sv
// Bench for memory_bus_responder: directed steps plus a randomized phase,
// all checked against a transaction-level reference model.
module tb_memory_bus_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        strobe;
    logic        isWrite;
    logic [14:0] address;
    logic [3:0]  writeMask;
    logic [31:0] dataWrite;
    logic        ready;
    logic        error;
    logic [31:0] dataRead;
    logic        btnA, btnB;
    logic        red, green, blue;
    logic [7:0]  bits;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] ref_mem [int];
    int          pool[$];
    logic [7:0]  ref_bits;
    logic [2:0]  ref_rgb;

    // Back-to-back bookkeeping
    int          r1, r2;
    logic [31:0] d1, d2;

    memory_bus_responder dut (
        .clock     (clock),
        .reset     (reset),
        .strobe    (strobe),
        .isWrite   (isWrite),
        .address   (address),
        .writeMask (writeMask),
        .dataWrite (dataWrite),
        .ready     (ready),
        .error     (error),
        .dataRead  (dataRead),
        .btnA      (btnA),
        .btnB      (btnB),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .bits      (bits)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction-level model: decode by plain arithmetic, update state, predict response.
    task automatic model_apply(input bit wr, input logic [14:0] a, input logic [3:0] m,
                               input logic [31:0] d, output int lat, output bit err,
                               output logic [31:0] q, output bit qvalid);
        int          ai;
        int          w;
        int          off;
        logic [31:0] old;
        ai     = int'(a);
        lat    = 1;
        err    = 0;
        q      = 0;
        qvalid = 0;
        if ((ai % 4) != 0 || !((ai < 4 * 2048) || (ai >= 'h7F00 && ai < 'h8000))) begin
            err    = 1;
            qvalid = 1;
        end else if (ai < 4 * 2048) begin
            w = ai / 4;
            if (wr) begin
                old = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (m[b]) old[8*b +: 8] = d[8*b +: 8];
                if (!ref_mem.exists(w)) pool.push_back(w);
                ref_mem[w] = old;
            end else begin
                lat = 2;
                if (ref_mem.exists(w)) begin
                    q      = ref_mem[w];
                    qvalid = 1;
                end
            end
        end else begin
            off = ai - 'h7F00;
            if (wr) begin
                if (m[0] && off == 0) ref_rgb = d[2:0];
                if (m[0] && off == 4) ref_bits = d[7:0];
            end else begin
                qvalid = 1;
                if (off == 0) q = {29'b0, ref_rgb};
                else if (off == 4) q = {24'b0, ref_bits};
                else if (off == 8) q = {30'b0, btnB, btnA};
            end
        end
    endtask

    // Drive one request, wait (bounded) for ready, then confirm the pulse is one cycle.
    task automatic xact(input bit wr, input logic [14:0] a, input logic [3:0] m,
                        input logic [31:0] d, output int lat, output logic e,
                        output logic [31:0] q, output logic [10:0] leds);
        bit seen;
        seen = 0;
        @(negedge clock);
        strobe = 1'b1; isWrite = wr; address = a; writeMask = m; dataWrite = d;
        lat = -1; e = 1'bx; q = 'x; leds = 'x;
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clock);
            if (ready === 1'b1) begin
                seen = 1; lat = i; e = error; q = dataRead;
                leds = {blue, green, red, bits};
            end
        end
        strobe = 1'b0; isWrite = 1'b0; address = '0; writeMask = '0; dataWrite = '0;
        @(negedge clock);
        chk("pulse", {31'b0, ready}, 32'h0);
    endtask

    task automatic run(input string tag, input bit wr, input logic [14:0] a,
                       input logic [3:0] m, input logic [31:0] d);
        int          lat, elat;
        logic        e;
        bit          eerr, qv;
        logic [31:0] q, eq;
        logic [10:0] leds;
        model_apply(wr, a, m, d, elat, eerr, eq, qv);
        xact(wr, a, m, d, lat, e, q, leds);
        chk({tag, "/lat"}, 32'(lat), 32'(elat));
        chk({tag, "/err"}, {31'b0, e}, {31'b0, eerr});
        if (qv) chk({tag, "/data"}, q, eq);
        chk({tag, "/leds"}, {21'b0, leds}, {21'b0, ref_rgb, ref_bits});
    endtask

    initial begin
        reset = 1'b1; strobe = 1'b0; isWrite = 1'b0; address = '0;
        writeMask = '0; dataWrite = '0; btnA = 1'b0; btnB = 1'b0;
        ref_bits = '0; ref_rgb = '0;

        // Reset values and quiet idle
        repeat (3) @(negedge clock);
        chk("reset_outs", {18'b0, ready, error, blue, green, red, bits}, 32'h0);
        chk("reset_data", dataRead, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("idle", {18'b0, ready, error, blue, green, red, bits}, 32'h0);
        end

        // RAM write/read and masked merge
        run("wr10", 1, 15'h0010, 4'hF, 32'hDEADBEEF);
        run("rd10", 0, 15'h0010, 4'h0, 32'h0);
        run("wrmask", 1, 15'h0010, 4'b0101, 32'h11223344);
        run("rdmask", 0, 15'h0010, 4'h3, 32'h0);
        run("wrmask0", 1, 15'h0010, 4'h0, 32'hFFFFFFFF);
        run("rdmask0", 0, 15'h0010, 4'hF, 32'h0);

        // RAM bounds
        run("wrlast", 1, 15'h1FFC, 4'hF, 32'hCAFEF00D);
        run("rdlast", 0, 15'h1FFC, 4'h0, 32'h0);
        run("rdpast", 0, 15'h2000, 4'h0, 32'h0);

        // IO LEDs
        run("wrbits", 1, 15'h7F04, 4'h1, 32'h0000005A);
        run("wrrgb", 1, 15'h7F00, 4'h1, 32'hFFFFFF07);
        run("rdbits", 0, 15'h7F04, 4'h0, 32'h0);
        run("rdrgb", 0, 15'h7F00, 4'h0, 32'h0);
        run("wrbits_nob0", 1, 15'h7F04, 4'hE, 32'hFFFFFFFF);
        run("rdbits2", 0, 15'h7F04, 4'h0, 32'h0);

        // Buttons through the synchroniser
        btnA = 1'b1; btnB = 1'b0;
        repeat (3) @(negedge clock);
        run("btnA", 0, 15'h7F08, 4'h0, 32'h0);
        btnB = 1'b1;
        repeat (3) @(negedge clock);
        run("btnAB", 0, 15'h7F08, 4'h0, 32'h0);
        run("wrbtn", 1, 15'h7F08, 4'hF, 32'h0);
        run("rdhole", 0, 15'h7F10, 4'h0, 32'h0);
        run("rdtop", 0, 15'h7FFC, 4'h0, 32'h0);

        // Errors: misaligned, unmapped, just below the IO window; RAM untouched
        run("mis", 0, 15'h0012, 4'h0, 32'h0);
        run("unmap", 0, 15'h4000, 4'h0, 32'h0);
        run("below_io", 0, 15'h7EFC, 4'h0, 32'h0);
        run("miswr", 1, 15'h0011, 4'hF, 32'h01020304);
        run("unmapwr", 1, 15'h4000, 4'hF, 32'h01020304);
        run("rd10_after_err", 0, 15'h0010, 4'h0, 32'h0);

        // Back-to-back reads with strobe held across the ready cycle
        run("wr0", 1, 15'h0000, 4'hF, $urandom);
        run("wr4", 1, 15'h0004, 4'hF, $urandom);
        r1 = -1; r2 = -1; d1 = 'x; d2 = 'x;
        @(negedge clock);
        strobe = 1'b1; isWrite = 1'b0; address = 15'h0000; writeMask = 4'h0;
        for (int i = 1; i <= 12 && r2 < 0; i++) begin
            @(negedge clock);
            if (ready === 1'b1) begin
                if (r1 < 0) begin
                    r1 = i; d1 = dataRead; address = 15'h0004;
                end else begin
                    r2 = i; d2 = dataRead; strobe = 1'b0;
                end
            end
        end
        strobe = 1'b0;
        chk("b2b_first_lat", 32'(r1), 32'd2);
        chk("b2b_gap", 32'(r2 - r1), 32'd3);
        chk("b2b_d0", d1, ref_mem[0]);
        chk("b2b_d4", d2, ref_mem[1]);

        // Reset while in RAM_READ: no ready, outputs cleared, next read served
        @(negedge clock);
        strobe = 1'b1; isWrite = 1'b0; address = 15'h0010;
        @(negedge clock);
        reset = 1'b1; strobe = 1'b0;
        @(negedge clock);
        chk("rst_noready1", {31'b0, ready}, 32'h0);
        @(negedge clock);
        chk("rst_noready2", {31'b0, ready}, 32'h0);
        reset = 1'b0;
        ref_bits = '0; ref_rgb = '0;
        chk("rst_leds", {21'b0, blue, green, red, bits}, 32'h0);
        chk("rst_data", dataRead, 32'h0);
        run("rd_after_rst", 0, 15'h0010, 4'h0, 32'h0);

        // Randomized mix checked against the model
        for (int n = 0; n < 120; n++) begin
            int          op;
            logic [14:0] a;
            logic [31:0] d;
            logic [3:0]  m;
            op = int'($urandom_range(0, 6));
            d  = $urandom;
            m  = 4'($urandom_range(0, 15));
            case (op)
                0: begin
                    a = 15'($urandom_range(0, 2047) * 4);
                    run("r_wrfull", 1, a, 4'hF, d);
                end
                1: begin
                    a = 15'(pool[$urandom_range(0, pool.size() - 1)] * 4);
                    run("r_wrpart", 1, a, m, d);
                end
                2, 3: begin
                    a = 15'(pool[$urandom_range(0, pool.size() - 1)] * 4);
                    run("r_rdram", 0, a, m, d);
                end
                4: begin
                    a = 15'('h7F00 + 4 * $urandom_range(0, 4));
                    run("r_wrio", 1, a, m, d);
                end
                5: begin
                    a = 15'('h7F00 + 4 * $urandom_range(0, 63));
                    run("r_rdio", 0, a, m, d);
                end
                default: begin
                    if ($urandom_range(0, 1) == 0)
                        a = 15'($urandom_range(0, 8191) | 1);
                    else
                        a = 15'($urandom_range('h2000 / 4, 'h7EFC / 4) * 4);
                    run("r_err", 1'($urandom_range(0, 1)), a, m, d);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
